multicycle_control_unit: RTL and testbench
==========================================

// Module: multicycle_control_unit
// PURPOSE
//   Control FSM for the multicycle RV32I datapath; next generation of the single-cycle controller.
//   Decodes op/funct3/funct7 into Moore-style datapath strobes over FETCH..WRITEBACK states.
//   Sequences memory accesses with a ready handshake and generalises the ALU-control width.
//   Emits one instrDone pulse per retired instruction. Sits between the instruction register and the datapath.
// PARAMETERS
//   ALU_CTRL_W  3  aluControl width. 3: add/sub/and/or/slt. 4: also xor, sltu, sll, srl, sra.
//   MEM_WAIT    1  1: FETCH/MEMREAD/MEMWRITE hold until memReady=1. 0: memReady ignored, 1 cycle each.
// PORTS
//   clk         in   1            rising-edge clock
//   rst_n       in   1            synchronous reset, active-low
//   op          in   7            instruction opcode (IR[6:0])
//   funct3      in   3            IR[14:12]
//   funct7      in   1            IR[30]
//   zero        in   1            ALU result == 0
//   lt          in   1            signed rs1 < rs2 (used only with BRANCH_EXT_EN)
//   ltu         in   1            unsigned rs1 < rs2 (used only with BRANCH_EXT_EN)
//   memReady    in   1            memory access complete this cycle
//   pcWrite     out  1            PC load enable
//   adrSrc      out  1            memory address: 0=PC, 1=ALUOut
//   irWrite     out  1            IR and oldPC load enable
//   memWrite    out  1            data memory write strobe
//   regWrite    out  1            register file write enable
//   resultSrc   out  2            00=ALUOut, 01=Data, 10=ALUResult
//   aluSrcA     out  2            00=PC, 01=oldPC, 10=rs1
//   aluSrcB     out  2            00=rs2, 01=imm, 10=const 4
//   inmSrc      out  2            00=I, 01=S, 10=B, 11=J
//   aluControl  out  ALU_CTRL_W   ALU operation; see BEHAVIOUR
//   illegal     out  1            1-cycle pulse in DECODE for an unsupported op/funct3
//   instrDone   out  1            1-cycle pulse on the last state of each instruction
// BEHAVIOUR
//   Reset and output timing
//   - Reset state is FETCH.
//   - While rst_n=0, pcWrite, irWrite, memWrite, regWrite, illegal and instrDone are forced to 0.
//   - All other outputs are 0 during reset.
//   - The first FETCH strobes occur on the cycle after rst_n rises.
//   - Reset mid-instruction aborts the instruction; the next state is FETCH and no writes occur.
//   - Outputs are combinational functions of state plus inputs; next state is registered.
//   State sequence and outputs
//   - FETCH: adrSrc=0, aluSrcA=00, aluSrcB=10, add, resultSrc=10.
//     - irWrite=pcWrite=1 only when memReady (or MEM_WAIT=0), then go to DECODE; otherwise stay in FETCH.
//   - DECODE: aluSrcA=01, aluSrcB=01, add (forms branch/jal target). Next state by op:
//     - 0000011 or 0100011 -> MEMADR
//     - 0110011 -> EXECR
//     - 0010011 -> EXECI
//     - 1101111 -> JAL
//     - 1100011 -> BRANCH
//     - else -> FETCH with illegal=1 and instrDone=0
//   - MEMADR: aluSrcA=10, aluSrcB=01, add. Go to MEMREAD for lw, MEMWRITE for sw.
//   - MEMREAD: adrSrc=1, resultSrc=00. Hold until ready, then MEMWB.
//   - MEMWB: resultSrc=01, regWrite=1, instrDone=1 -> FETCH.
//   - MEMWRITE: adrSrc=1, memWrite=1 held while waiting. On ready: instrDone=1 -> FETCH.
//   - EXECR: aluSrcA=10, aluSrcB=00, funct-decoded op -> ALUWB.
//   - EXECI: aluSrcA=10, aluSrcB=01, funct-decoded op -> ALUWB.
//     - funct7 is ignored for addi (no subi); for srai funct7 is honoured.
//   - ALUWB: resultSrc=00, regWrite=1, instrDone=1 -> FETCH.
//   - JAL: aluSrcA=01, aluSrcB=10, add, resultSrc=00, pcWrite=1 -> ALUWB (writes PC+4 to rd).
//   - BRANCH: aluSrcA=10, aluSrcB=00, sub, resultSrc=00, pcWrite=taken, instrDone=1 -> FETCH.
//   inmSrc by op: lw/I-ALU=00, sw=01, branch=10, jal=11.
//   aluControl encoding
//   - Codes: add=0, sub=1, and=2, or=3, slt=5.
//   - ALU_CTRL_W=4 adds: xor=4, sltu=6, sll=7, srl=8, sra=9.
//   - Ops unsupported at the configured width decode as illegal in DECODE.
// CONFIGURATION
//   BRANCH_EXT_EN defined: taken = beq:zero, bne:~zero, blt:lt, bge:~lt, bltu:ltu, bgeu:~ltu.
//   BRANCH_EXT_EN undefined: only beq (funct3=000) is legal; taken=zero.
//     Other branch funct3 values are illegal; lt and ltu are ignored.
// TESTING
//   Reset: hold rst_n=0 for 3 cycles with op=lw -> all write strobes 0; FETCH strobes on cycle 1 after release.
//   lw, memReady=1 -> FETCH,DECODE,MEMADR,MEMREAD,MEMWB (5 cycles); regWrite and resultSrc=01 in cycle 5; one instrDone.
//   sw, MEM_WAIT=1, memReady low for 3 cycles in MEMWRITE -> memWrite high 4 cycles; 1 instrDone; no regWrite.
//   add/sub R-type (funct7=1, funct3=000) -> EXECR aluControl=1; ALUWB regWrite=1; 4 cycles total.
//   beq with zero=0 -> pcWrite=0 in BRANCH; with zero=1 -> pcWrite=1. bne illegal unless BRANCH_EXT_EN.
//   op=0000000 -> illegal pulse in DECODE, back to FETCH, no instrDone/regWrite; rst_n=0 in MEMREAD -> FETCH.

Source files
------------

// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - multicycle RV32I control FSM (optional macro: BRANCH_EXT_EN)
module multicycle_control_unit #(
    parameter int ALU_CTRL_W = 3,
    parameter bit MEM_WAIT   = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [6:0]            op,
    input  logic [2:0]            funct3,
    input  logic                  funct7,
    input  logic                  zero,
    input  logic                  lt,
    input  logic                  ltu,
    input  logic                  memReady,
    output logic                  pcWrite,
    output logic                  adrSrc,
    output logic                  irWrite,
    output logic                  memWrite,
    output logic                  regWrite,
    output logic [1:0]            resultSrc,
    output logic [1:0]            aluSrcA,
    output logic [1:0]            aluSrcB,
    output logic [1:0]            inmSrc,
    output logic [ALU_CTRL_W-1:0] aluControl,
    output logic                  illegal,
    output logic                  instrDone
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;

    // Extended ALU operations only exist when the control bus can carry them
    localparam bit WIDE_ALU = (ALU_CTRL_W >= 4);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_JAL      = 4'd9,
        S_BRANCH   = 4'd10
    } state_t;

    state_t      r_state;

    logic        w_ready;
    logic [3:0]  w_alu_code;
    logic        w_alu_ok;
    logic        w_br_ok;
    logic        w_taken;
    logic        w_op_legal;
    logic [3:0]  w_alu_sel;

    // With MEM_WAIT=0 every memory state completes in a single cycle
    assign w_ready = MEM_WAIT ? memReady : 1'b1;

    // Decode funct3/funct7 into an ALU operation and check it fits the configured width
    always_comb begin
        w_alu_code = ALU_ADD;
        w_alu_ok   = 1'b0;
        case (funct3)
            3'b000: begin
                w_alu_ok   = 1'b1;
                // IR[30] is an immediate bit for addi, so only R-type selects sub
                w_alu_code = (op == OP_RTYPE && funct7) ? ALU_SUB : ALU_ADD;
            end
            3'b111: begin w_alu_ok = 1'b1;     w_alu_code = ALU_AND;  end
            3'b110: begin w_alu_ok = 1'b1;     w_alu_code = ALU_OR;   end
            3'b010: begin w_alu_ok = 1'b1;     w_alu_code = ALU_SLT;  end
            3'b100: begin w_alu_ok = WIDE_ALU; w_alu_code = ALU_XOR;  end
            3'b011: begin w_alu_ok = WIDE_ALU; w_alu_code = ALU_SLTU; end
            3'b001: begin w_alu_ok = WIDE_ALU; w_alu_code = ALU_SLL;  end
            3'b101: begin
                w_alu_ok   = WIDE_ALU;
                w_alu_code = funct7 ? ALU_SRA : ALU_SRL;
            end
            default: begin w_alu_ok = 1'b0; w_alu_code = ALU_ADD; end
        endcase
        // IR[30] set is only meaningful for sub/sra (R-type) and srai (I-type)
        if (op == OP_RTYPE && funct7 && funct3 != 3'b000 && funct3 != 3'b101)
            w_alu_ok = 1'b0;
        if (op == OP_ITYPE && funct7 && funct3 == 3'b001)
            w_alu_ok = 1'b0;
    end

`ifdef BRANCH_EXT_EN
    // Full branch set: condition chosen by funct3
    always_comb begin
        w_br_ok = 1'b1;
        w_taken = 1'b0;
        case (funct3)
            3'b000:  w_taken = zero;
            3'b001:  w_taken = ~zero;
            3'b100:  w_taken = lt;
            3'b101:  w_taken = ~lt;
            3'b110:  w_taken = ltu;
            3'b111:  w_taken = ~ltu;
            default: w_br_ok = 1'b0;
        endcase
    end
`else
    // Only beq exists; the comparator flags are not consulted
    logic w_unused_cmp;
    assign w_unused_cmp = lt ^ ltu;
    assign w_br_ok      = (funct3 == 3'b000);
    assign w_taken      = zero;
`endif

    // Whole-instruction legality checked once, in DECODE
    always_comb begin
        w_op_legal = 1'b0;
        case (op)
            OP_LOAD, OP_STORE:  w_op_legal = (funct3 == 3'b010);
            OP_RTYPE, OP_ITYPE: w_op_legal = w_alu_ok;
            OP_JAL:             w_op_legal = 1'b1;
            OP_BRANCH:          w_op_legal = w_br_ok;
            default:            w_op_legal = 1'b0;
        endcase
    end

    // State register; reset aborts any instruction in flight
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
        end else begin
            case (r_state)
                S_FETCH:    if (w_ready) r_state <= S_DECODE;
                S_DECODE: begin
                    if (!w_op_legal)
                        r_state <= S_FETCH;
                    else begin
                        case (op)
                            OP_LOAD, OP_STORE: r_state <= S_MEMADR;
                            OP_RTYPE:          r_state <= S_EXECR;
                            OP_ITYPE:          r_state <= S_EXECI;
                            OP_JAL:            r_state <= S_JAL;
                            OP_BRANCH:         r_state <= S_BRANCH;
                            default:           r_state <= S_FETCH;
                        endcase
                    end
                end
                S_MEMADR:   r_state <= (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
                S_MEMREAD:  if (w_ready) r_state <= S_MEMWB;
                S_MEMWB:    r_state <= S_FETCH;
                S_MEMWRITE: if (w_ready) r_state <= S_FETCH;
                S_EXECR:    r_state <= S_ALUWB;
                S_EXECI:    r_state <= S_ALUWB;
                S_ALUWB:    r_state <= S_FETCH;
                S_JAL:      r_state <= S_ALUWB;
                S_BRANCH:   r_state <= S_FETCH;
                default:    r_state <= S_FETCH;
            endcase
        end
    end

    // Datapath strobes from the current state (and memReady/zero); all quiet in reset
    always_comb begin
        pcWrite   = 1'b0;
        adrSrc    = 1'b0;
        irWrite   = 1'b0;
        memWrite  = 1'b0;
        regWrite  = 1'b0;
        resultSrc = 2'b00;
        aluSrcA   = 2'b00;
        aluSrcB   = 2'b00;
        illegal   = 1'b0;
        instrDone = 1'b0;
        w_alu_sel = ALU_ADD;

        case (op)
            OP_STORE:  inmSrc = 2'b01;
            OP_BRANCH: inmSrc = 2'b10;
            OP_JAL:    inmSrc = 2'b11;
            default:   inmSrc = 2'b00;
        endcase

        case (r_state)
            S_FETCH: begin
                aluSrcA   = 2'b00;
                aluSrcB   = 2'b10;
                resultSrc = 2'b10;
                irWrite   = w_ready;
                pcWrite   = w_ready;
            end
            S_DECODE: begin
                aluSrcA = 2'b01;
                aluSrcB = 2'b01;
                illegal = ~w_op_legal;
            end
            S_MEMADR: begin
                aluSrcA = 2'b10;
                aluSrcB = 2'b01;
            end
            S_MEMREAD: begin
                adrSrc    = 1'b1;
                resultSrc = 2'b00;
            end
            S_MEMWB: begin
                resultSrc = 2'b01;
                regWrite  = 1'b1;
                instrDone = 1'b1;
            end
            S_MEMWRITE: begin
                adrSrc    = 1'b1;
                memWrite  = 1'b1;
                instrDone = w_ready;
            end
            S_EXECR: begin
                aluSrcA   = 2'b10;
                aluSrcB   = 2'b00;
                w_alu_sel = w_alu_code;
            end
            S_EXECI: begin
                aluSrcA   = 2'b10;
                aluSrcB   = 2'b01;
                w_alu_sel = w_alu_code;
            end
            S_ALUWB: begin
                resultSrc = 2'b00;
                regWrite  = 1'b1;
                instrDone = 1'b1;
            end
            S_JAL: begin
                aluSrcA   = 2'b01;
                aluSrcB   = 2'b10;
                resultSrc = 2'b00;
                pcWrite   = 1'b1;
            end
            S_BRANCH: begin
                aluSrcA   = 2'b10;
                aluSrcB   = 2'b00;
                w_alu_sel = ALU_SUB;
                resultSrc = 2'b00;
                pcWrite   = w_taken;
                instrDone = 1'b1;
            end
            default: begin
                pcWrite = 1'b0;
            end
        endcase

        if (!rst_n) begin
            pcWrite   = 1'b0;
            adrSrc    = 1'b0;
            irWrite   = 1'b0;
            memWrite  = 1'b0;
            regWrite  = 1'b0;
            resultSrc = 2'b00;
            aluSrcA   = 2'b00;
            aluSrcB   = 2'b00;
            inmSrc    = 2'b00;
            illegal   = 1'b0;
            instrDone = 1'b0;
            w_alu_sel = ALU_ADD;
        end
    end

    assign aluControl = w_alu_sel[ALU_CTRL_W-1:0];

endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb/tb_multicycle_control_unit.sv - directed self-checking bench for multicycle_control_unit
module tb_multicycle_control_unit;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_BR   = 7'b1100011;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7;
    logic       zero;
    logic       lt;
    logic       ltu;
    logic       memReady;
    logic       pcWrite, adrSrc, irWrite, memWrite, regWrite, illegal, instrDone;
    logic [1:0] resultSrc, aluSrcA, aluSrcB, inmSrc;
    logic [2:0] aluControl;

    int checks = 0;
    int errors = 0;

    wire [17:0] obs = {pcWrite, adrSrc, irWrite, memWrite, regWrite, resultSrc,
                       aluSrcA, aluSrcB, inmSrc, aluControl, illegal, instrDone};

    multicycle_control_unit #(.ALU_CTRL_W(3), .MEM_WAIT(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7(funct7),
        .zero(zero), .lt(lt), .ltu(ltu), .memReady(memReady),
        .pcWrite(pcWrite), .adrSrc(adrSrc), .irWrite(irWrite), .memWrite(memWrite),
        .regWrite(regWrite), .resultSrc(resultSrc), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB),
        .inmSrc(inmSrc), .aluControl(aluControl), .illegal(illegal), .instrDone(instrDone)
    );

    always #5 clk = ~clk;

    function automatic logic [17:0] pk(input logic pc, input logic adr, input logic ir,
                                       input logic mw, input logic rw, input logic [1:0] rs,
                                       input logic [1:0] sa, input logic [1:0] sb,
                                       input logic [1:0] imm, input logic [2:0] alu,
                                       input logic ill, input logic done);
        return {pc, adr, ir, mw, rw, rs, sa, sb, imm, alu, ill, done};
    endfunction

    // Expected per-state vectors (imm field supplied by the caller)
    function automatic logic [17:0] v_fetch(input logic [1:0] imm);
        return pk(1, 0, 1, 0, 0, 2'b10, 2'b00, 2'b10, imm, 3'd0, 0, 0);
    endfunction
    function automatic logic [17:0] v_decode(input logic [1:0] imm, input logic ill);
        return pk(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, imm, 3'd0, ill, 0);
    endfunction
    function automatic logic [17:0] v_aluwb(input logic [1:0] imm);
        return pk(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, imm, 3'd0, 0, 1);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; op = OP_LW; funct3 = 3'b010; funct7 = 1'b0; memReady = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== 18'd0) begin
                errors++;
                $display("FAIL reset cycle %0d: got %b expected %b", i, obs, 18'd0);
            end
            tick();
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (obs !== v_fetch(2'b00)) begin
            errors++;
            $display("FAIL reset release fetch: got %b expected %b", obs, v_fetch(2'b00));
        end
        tick();
    endtask

    task automatic test_lw();
        logic [17:0] e [6];
        int done_cnt;
        e = '{v_fetch(2'b00), v_decode(2'b00, 1'b0),
              pk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 3'd0, 0, 0),
              pk(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'd0, 0, 0),
              pk(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 2'b00, 3'd0, 0, 1),
              v_fetch(2'b00)};
        do_reset();
        op = OP_LW; funct3 = 3'b010; funct7 = 1'b0; memReady = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i < 5) done_cnt += int'(instrDone);
            checks++;
            if (obs !== e[i]) begin
                errors++;
                $display("FAIL lw cycle %0d: got %b expected %b", i, obs, e[i]);
            end
            tick();
        end
        checks++;
        if (done_cnt !== 1) begin
            errors++;
            $display("FAIL lw instrDone count: got %0d expected 1", done_cnt);
        end
    endtask

    task automatic test_sw_wait();
        logic [17:0] e [9];
        logic        rdy [9];
        int mw_cnt, rw_cnt, done_cnt;
        e = '{pk(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b01, 3'd0, 0, 0),
              v_fetch(2'b01), v_decode(2'b01, 1'b0),
              pk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b01, 3'd0, 0, 0),
              pk(0, 1, 0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b01, 3'd0, 0, 0),
              pk(0, 1, 0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b01, 3'd0, 0, 0),
              pk(0, 1, 0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b01, 3'd0, 0, 0),
              pk(0, 1, 0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b01, 3'd0, 0, 1),
              v_fetch(2'b01)};
        rdy = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        do_reset();
        op = OP_SW; funct3 = 3'b010; funct7 = 1'b0;
        mw_cnt = 0; rw_cnt = 0; done_cnt = 0;
        for (int i = 0; i < 9; i++) begin
            memReady = rdy[i];
            @(negedge clk);
            if (i < 8) begin
                mw_cnt   += int'(memWrite);
                rw_cnt   += int'(regWrite);
                done_cnt += int'(instrDone);
            end
            checks++;
            if (obs !== e[i]) begin
                errors++;
                $display("FAIL sw cycle %0d: got %b expected %b", i, obs, e[i]);
            end
            tick();
        end
        checks++;
        if (mw_cnt !== 4 || rw_cnt !== 0 || done_cnt !== 1) begin
            errors++;
            $display("FAIL sw counts: got memWrite=%0d regWrite=%0d instrDone=%0d expected 4 0 1",
                     mw_cnt, rw_cnt, done_cnt);
        end
    endtask

    task automatic test_rtype_sub();
        logic [17:0] e [5];
        e = '{v_fetch(2'b00), v_decode(2'b00, 1'b0),
              pk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b00, 3'd1, 0, 0),
              v_aluwb(2'b00), v_fetch(2'b00)};
        do_reset();
        op = OP_R; funct3 = 3'b000; funct7 = 1'b1; memReady = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== e[i]) begin
                errors++;
                $display("FAIL sub cycle %0d: got %b expected %b", i, obs, e[i]);
            end
            tick();
        end
    endtask

    task automatic test_addi_funct7();
        logic [17:0] e [4];
        e = '{v_fetch(2'b00), v_decode(2'b00, 1'b0),
              pk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 3'd0, 0, 0),
              v_aluwb(2'b00)};
        do_reset();
        op = OP_I; funct3 = 3'b000; funct7 = 1'b1; memReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== e[i]) begin
                errors++;
                $display("FAIL addi cycle %0d: got %b expected %b", i, obs, e[i]);
            end
            tick();
        end
    endtask

    task automatic test_beq();
        logic [17:0] e [4];
        for (int z = 0; z < 2; z++) begin
            e = '{v_fetch(2'b10), v_decode(2'b10, 1'b0),
                  pk(z[0], 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 3'd1, 0, 1),
                  v_fetch(2'b10)};
            do_reset();
            op = OP_BR; funct3 = 3'b000; funct7 = 1'b0; memReady = 1'b1; zero = z[0];
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                checks++;
                if (obs !== e[i]) begin
                    errors++;
                    $display("FAIL beq zero=%0d cycle %0d: got %b expected %b", z, i, obs, e[i]);
                end
                tick();
            end
        end
        zero = 1'b0;
    endtask

    task automatic test_jal();
        logic [17:0] e [5];
        e = '{v_fetch(2'b11), v_decode(2'b11, 1'b0),
              pk(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b11, 3'd0, 0, 0),
              v_aluwb(2'b11), v_fetch(2'b11)};
        do_reset();
        op = OP_JAL; funct3 = 3'b000; funct7 = 1'b0; memReady = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== e[i]) begin
                errors++;
                $display("FAIL jal cycle %0d: got %b expected %b", i, obs, e[i]);
            end
            tick();
        end
    endtask

    task automatic test_illegal();
        logic [6:0]  ops  [3];
        logic [2:0]  f3s  [3];
        logic [1:0]  imms [3];
        logic [17:0] e;
        ops  = '{7'b0000000, OP_BR, OP_R};
        f3s  = '{3'b000, 3'b001, 3'b100};
        imms = '{2'b00, 2'b10, 2'b00};
        for (int k = 0; k < 3; k++) begin
            do_reset();
            op = ops[k]; funct3 = f3s[k]; funct7 = 1'b0; memReady = 1'b1;
            for (int i = 0; i < 3; i++) begin
                e = (i == 1) ? v_decode(imms[k], 1'b1) : v_fetch(imms[k]);
                @(negedge clk);
                checks++;
                if (obs !== e) begin
                    errors++;
                    $display("FAIL illegal case %0d cycle %0d: got %b expected %b", k, i, obs, e);
                end
                tick();
            end
        end
    endtask

    task automatic test_reset_midinstr();
        logic [17:0] e;
        do_reset();
        op = OP_LW; funct3 = 3'b010; funct7 = 1'b0; memReady = 1'b1;
        tick(); tick(); tick();
        memReady = 1'b0;
        e = pk(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'd0, 0, 0);
        @(negedge clk);
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL midreset memread: got %b expected %b", obs, e);
        end
        tick();
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (obs !== 18'd0) begin
            errors++;
            $display("FAIL midreset held: got %b expected %b", obs, 18'd0);
        end
        tick();
        rst_n = 1'b1; memReady = 1'b1;
        @(negedge clk);
        checks++;
        if (obs !== v_fetch(2'b00)) begin
            errors++;
            $display("FAIL midreset fetch: got %b expected %b", obs, v_fetch(2'b00));
        end
        tick();
    endtask

    initial begin
        rst_n = 1'b0; op = 7'd0; funct3 = 3'd0; funct7 = 1'b0;
        zero = 1'b0; lt = 1'b0; ltu = 1'b0; memReady = 1'b0;
        test_reset();
        test_lw();
        test_sw_wait();
        test_rtype_sub();
        test_addi_funct7();
        test_beq();
        test_jal();
        test_illegal();
        test_reset_midinstr();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
